// File: rtl/iob_ila_dump_ctrl_if.sv
// IOb-native request/response bus between the ILA dump sequencer (master)
// and the ILA software-register file (slave).
interface iob_ila_dump_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) ();
  logic                  avalid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output avalid, addr, wdata, wstrb,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  avalid, addr, wdata, wstrb,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/iob_ila_dump_ctrl.sv
// ILA readout sequencer: reads N_SAMPLES, then for every sample index writes
// INDEX, walks SIGNAL_SELECT over all slices, reads SAMPLE_DATA and pushes each
// word onto a valid/ready stream. Every request state leaves avalid low for one
// cycle before issuing, so a new request never follows an acceptance directly
// and aborts are only taken while no request is on the bus.
module iob_ila_dump_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int BUFFER_W   = 5,
  parameter int N_SEL      = 1,
  parameter int NSAMP_ADDR = 9,
  parameter int INDEX_ADDR = 6,
  parameter int SEL_ADDR   = 7,
  parameter int SDATA_ADDR = 8
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o,
  iob_ila_dump_ctrl_if.master iob,
  output logic [DATA_W-1:0]   data_o,
  output logic [BUFFER_W-1:0] idx_o,
  output logic [7:0]          sel_o,
  output logic                last_o,
  output logic                valid_o,
  input  logic                ready_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [BUFFER_W:0] NS_MAX  = {1'b1, {BUFFER_W{1'b0}}};
  localparam logic [BUFFER_W:0] IDX_ONE = {{BUFFER_W{1'b0}}, 1'b1};
  localparam logic [7:0]        SEL_LAST = 8'(N_SEL - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD_NS  = 4'd1,
    S_W_NS   = 4'd2,
    S_WR_IDX = 4'd3,
    S_WR_SEL = 4'd4,
    S_RD_SD  = 4'd5,
    S_W_SD   = 4'd6,
    S_PUSH   = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  // Sample count is taken from the low BUFFER_W+1 bits and clipped to the buffer depth.
  function automatic logic [BUFFER_W:0] sat_nsamp(input logic [DATA_W-1:0] rd);
    if (rd[BUFFER_W:0] > NS_MAX) begin
      return NS_MAX;
    end else begin
      return rd[BUFFER_W:0];
    end
  endfunction

  state_t                state_r, state_s;
  logic                  avalid_r, avalid_s;
  logic [ADDR_W-1:0]     addr_r, addr_s;
  logic [DATA_W-1:0]     wdata_r, wdata_s;
  logic [STRB_W-1:0]     wstrb_r, wstrb_s;
  logic [BUFFER_W:0]     nsamp_r, nsamp_s;
  logic [BUFFER_W:0]     idx_r, idx_s;
  logic [7:0]            sel_r, sel_s;
  logic [DATA_W-1:0]     data_r, data_s;
  logic [BUFFER_W-1:0]   strm_idx_r, strm_idx_s;
  logic [7:0]            strm_sel_r, strm_sel_s;
  logic                  last_r, last_s;
  logic                  valid_r, valid_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  aborted_r, aborted_s;
  logic                  abort_pend_r, abort_pend_s;
  logic                  abort_now_s;
  logic [BUFFER_W:0]     nsamp_rd_s;
  logic [ADDR_W-1:0]     req_addr_s;
  logic [DATA_W-1:0]     req_wdata_s;
  logic                  req_wr_s;
  state_t                req_next_s;

  assign abort_now_s = abort_pend_r | abort_i;
  assign nsamp_rd_s  = sat_nsamp(iob.rdata);

  // Request contents and post-acceptance state for each bus-request state.
  always_comb begin
    req_addr_s  = '0;
    req_wdata_s = '0;
    req_wr_s    = 1'b0;
    req_next_s  = S_IDLE;
    case (state_r)
      S_RD_NS: begin
        req_addr_s = ADDR_W'(NSAMP_ADDR);
        req_next_s = S_W_NS;
      end
      S_WR_IDX: begin
        req_addr_s  = ADDR_W'(INDEX_ADDR);
        req_wdata_s = DATA_W'(idx_r);
        req_wr_s    = 1'b1;
        req_next_s  = S_WR_SEL;
      end
      S_WR_SEL: begin
        req_addr_s  = ADDR_W'(SEL_ADDR);
        req_wdata_s = DATA_W'(sel_r);
        req_wr_s    = 1'b1;
        req_next_s  = S_RD_SD;
      end
      S_RD_SD: begin
        req_addr_s = ADDR_W'(SDATA_ADDR);
        req_next_s = S_W_SD;
      end
      default: begin
        req_next_s = S_IDLE;
      end
    endcase
  end

  // Next-state and next-register computation for the whole sequencer.
  always_comb begin
    state_s      = state_r;
    avalid_s     = avalid_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    wstrb_s      = wstrb_r;
    nsamp_s      = nsamp_r;
    idx_s        = idx_r;
    sel_s        = sel_r;
    data_s       = data_r;
    strm_idx_s   = strm_idx_r;
    strm_sel_s   = strm_sel_r;
    last_s       = last_r;
    valid_s      = valid_r;
    aborted_s    = aborted_r;
    abort_pend_s = abort_pend_r | abort_i;
    case (state_r)
      S_IDLE, S_DONE: begin
        abort_pend_s = 1'b0;
        if (start_i) begin
          state_s   = S_RD_NS;
          aborted_s = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD_NS, S_WR_IDX, S_WR_SEL, S_RD_SD: begin
        if (!avalid_r) begin
          if (abort_now_s) begin
            state_s      = S_DONE;
            aborted_s    = 1'b1;
            abort_pend_s = 1'b0;
          end else begin
            avalid_s = 1'b1;
            addr_s   = req_addr_s;
            wdata_s  = req_wdata_s;
            wstrb_s  = req_wr_s ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
          end
        end else if (iob.ready) begin
          avalid_s = 1'b0;
          state_s  = req_next_s;
        end else begin
          state_s = state_r;
        end
      end
      S_W_NS: begin
        if (iob.rvalid) begin
          nsamp_s = nsamp_rd_s;
          idx_s   = '0;
          sel_s   = 8'd0;
          if (nsamp_rd_s == '0) begin
            state_s = S_DONE;
          end else begin
            state_s = S_WR_IDX;
          end
        end else begin
          state_s = S_W_NS;
        end
      end
      S_W_SD: begin
        if (iob.rvalid) begin
          data_s     = iob.rdata;
          strm_idx_s = idx_r[BUFFER_W-1:0];
          strm_sel_s = sel_r;
          last_s     = (idx_r == (nsamp_r - IDX_ONE)) && (sel_r == SEL_LAST);
          valid_s    = 1'b1;
          state_s    = S_PUSH;
        end else begin
          state_s = S_W_SD;
        end
      end
      S_PUSH: begin
        if (ready_i) begin
          valid_s = 1'b0;
          if (abort_now_s) begin
            state_s      = S_DONE;
            aborted_s    = 1'b1;
            abort_pend_s = 1'b0;
          end else if (sel_r < SEL_LAST) begin
            sel_s   = sel_r + 8'd1;
            state_s = S_WR_SEL;
          end else if (idx_r < (nsamp_r - IDX_ONE)) begin
            idx_s   = idx_r + IDX_ONE;
            sel_s   = 8'd0;
            state_s = S_WR_IDX;
          end else begin
            state_s = S_DONE;
          end
        end else begin
          state_s = S_PUSH;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s = (state_s != S_IDLE) && (state_s != S_DONE);
    done_s = (state_s == S_DONE);
  end

  // State and output registers; reset wins over the clock enable.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_r      <= S_IDLE;
      avalid_r     <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      wstrb_r      <= '0;
      nsamp_r      <= '0;
      idx_r        <= '0;
      sel_r        <= 8'd0;
      data_r       <= '0;
      strm_idx_r   <= '0;
      strm_sel_r   <= 8'd0;
      last_r       <= 1'b0;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      abort_pend_r <= 1'b0;
    end else if (cke_i) begin
      state_r      <= state_s;
      avalid_r     <= avalid_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      wstrb_r      <= wstrb_s;
      nsamp_r      <= nsamp_s;
      idx_r        <= idx_s;
      sel_r        <= sel_s;
      data_r       <= data_s;
      strm_idx_r   <= strm_idx_s;
      strm_sel_r   <= strm_sel_s;
      last_r       <= last_s;
      valid_r      <= valid_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      aborted_r    <= aborted_s;
      abort_pend_r <= abort_pend_s;
    end
  end

  assign iob.avalid = avalid_r;
  assign iob.addr   = addr_r;
  assign iob.wdata  = wdata_r;
  assign iob.wstrb  = wstrb_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign aborted_o  = aborted_r;
  assign data_o     = data_r;
  assign idx_o      = strm_idx_r;
  assign sel_o      = strm_sel_r;
  assign last_o     = last_r;
  assign valid_o    = valid_r;

endmodule

// File: tb/tb_iob_ila_dump_ctrl.sv
// Bench for iob_ila_dump_ctrl: an ILA register-file model with random
// handshake delays answers the bus, a stream sink applies backpressure, and
// every run is compared against the dump order derived from the sample count.
module tb_iob_ila_dump_ctrl;
  localparam int DATA_W = 32, ADDR_W = 4, BUFFER_W = 5, N_SEL = 2;
  localparam int NSAMP_A = 9, INDEX_A = 6, SEL_A = 7, SDATA_A = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        cke_i, arst_i, start_i, abort_i, ready_i;
  logic        busy_o, done_o, aborted_o, last_o, valid_o;
  logic [31:0] data_o;
  logic [4:0]  idx_o;
  logic [7:0]  sel_o;

  iob_ila_dump_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) iob ();

  iob_ila_dump_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUFFER_W(BUFFER_W), .N_SEL(N_SEL),
    .NSAMP_ADDR(NSAMP_A), .INDEX_ADDR(INDEX_A), .SEL_ADDR(SEL_A), .SDATA_ADDR(SDATA_A)
  ) dut (
    .clk_i(clk), .cke_i(cke_i), .arst_i(arst_i), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .iob(iob),
    .data_o(data_o), .idx_o(idx_o), .sel_o(sel_o), .last_o(last_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  typedef struct packed {logic [3:0] addr; logic [3:0] wstrb; logic [31:0] wdata;} bus_t;
  typedef struct packed {logic [31:0] data; logic [4:0] idx; logic [7:0] sel; logic last;} word_t;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // run configuration, written by the stimulus process only
  logic [31:0] cfg_ns, cfg_salt;
  int          cfg_rdy_hi, cfg_rv_lo, cfg_rv_hi;
  bit          cfg_bp, cfg_hold, cfg_ab, clr_req, abort_req;

  // model state, written by the model process only
  bus_t        bus_log[$];
  word_t       words[$];
  int          cyc, rdy_cnt, rv_cnt, sd_cnt, done_cnt, done_cyc, last_hs_cyc, rv_cyc, stab_bad;
  bit          acc_q, rd_pend, abort_now, wait_q;
  bus_t        req_q;
  logic [31:0] rd_val, index_reg, sel_reg;
  word_t       prev_w, cur_w;

  // ILA register-file model and stream sink, driven on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (clr_req) begin
      bus_log.delete(); words.delete();
      rdy_cnt = 0; rv_cnt = 0; sd_cnt = 0; done_cnt = 0; done_cyc = 0;
      last_hs_cyc = 0; rv_cyc = 0; stab_bad = 0;
      acc_q = 0; rd_pend = 0; abort_now = 0; wait_q = 0;
      index_reg = 0; sel_reg = 0; rd_val = 0;
      iob.ready = 1'b0; iob.rvalid = 1'b0; iob.rdata = 32'h0;
      ready_i = 1'b0; abort_i = 1'b0;
    end else begin
      if (acc_q) begin
        if (req_q.wstrb == 4'h0) req_q.wdata = 32'h0;
        bus_log.push_back(req_q);
        if (req_q.wstrb != 4'h0) begin
          if (req_q.addr == 4'(INDEX_A)) index_reg = req_q.wdata;
          if (req_q.addr == 4'(SEL_A)) sel_reg = req_q.wdata;
        end else begin
          rd_pend = 1;
          rv_cnt = int'($urandom_range(cfg_rv_hi, cfg_rv_lo));
          if (req_q.addr == 4'(NSAMP_A)) rd_val = cfg_ns;
          else rd_val = cfg_salt + index_reg * 16 + sel_reg;
          if (req_q.addr == 4'(SDATA_A)) begin
            sd_cnt++;
            if (cfg_ab && sd_cnt == 2) abort_now = 1;
          end
        end
      end
      iob.rvalid = 1'b0;
      if (rd_pend) begin
        if (rv_cnt == 0) begin
          iob.rvalid = 1'b1; iob.rdata = rd_val; rd_pend = 0; rv_cyc = cyc;
        end else begin
          rv_cnt--;
        end
      end
      acc_q = 0;
      iob.ready = 1'b0;
      if (iob.avalid === 1'b1) begin
        if (rdy_cnt == 0) begin
          iob.ready = 1'b1; acc_q = 1;
          req_q.addr = iob.addr; req_q.wstrb = iob.wstrb; req_q.wdata = iob.wdata;
          rdy_cnt = int'($urandom_range(cfg_rdy_hi, 0));
        end else begin
          rdy_cnt--;
        end
      end
      if (cfg_hold) ready_i = 1'b0;
      else if (cfg_bp) ready_i = ($urandom_range(3, 0) != 0);
      else ready_i = 1'b1;
      cur_w.data = data_o; cur_w.idx = idx_o; cur_w.sel = sel_o; cur_w.last = last_o;
      if (wait_q && !(valid_o === 1'b1 && cur_w === prev_w)) stab_bad++;
      if (valid_o === 1'b1 && ready_i) begin
        words.push_back(cur_w); last_hs_cyc = cyc;
      end
      wait_q = (valid_o === 1'b1) && !ready_i;
      prev_w = cur_w;
      if (done_o === 1'b1) begin
        done_cnt++; done_cyc = cyc;
      end
      abort_i = abort_now | abort_req;
      abort_now = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_run(input logic [31:0] ns, input logic [31:0] salt, input int rdy_hi,
                        input int rv_lo, input int rv_hi, input bit bp, input bit ab,
                        input bit poke, input bit sab, input string nm);
    cfg_ns = ns; cfg_salt = salt; cfg_rdy_hi = rdy_hi; cfg_rv_lo = rv_lo; cfg_rv_hi = rv_hi;
    cfg_bp = bp; cfg_ab = ab; cfg_hold = 0;
    clr_req = 1; step(); clr_req = 0;
    if (sab) begin
      abort_req = 1; step();
    end
    start_i = 1'b1; abort_req = 0; step(); start_i = 1'b0;
    for (int t = 0; t < 8000 && done_cnt == 0; t++) begin
      step();
      if (poke && t == 20) begin
        chk_eq({nm, "_busy_mid"}, busy_o, 1'b1);
        start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    chk_eq({nm, "_done_seen"}, done_cnt > 0, 1'b1);
    for (int t = 0; t < 4; t++) step();
  endtask

  task automatic check_run(input string nm, input int n_eff, input bit ab);
    int   n_words;
    bus_t exp_bus[$];
    bus_t e;
    n_words = ab ? 2 : n_eff * N_SEL;
    e.addr = 4'(NSAMP_A); e.wstrb = 4'h0; e.wdata = 32'h0; exp_bus.push_back(e);
    for (int i = 0; i < n_eff; i++) begin
      e.addr = 4'(INDEX_A); e.wstrb = 4'hF; e.wdata = i; exp_bus.push_back(e);
      for (int s = 0; s < N_SEL; s++) begin
        e.addr = 4'(SEL_A); e.wstrb = 4'hF; e.wdata = s; exp_bus.push_back(e);
        e.addr = 4'(SDATA_A); e.wstrb = 4'h0; e.wdata = 32'h0; exp_bus.push_back(e);
      end
    end
    if (ab) while (exp_bus.size() > 6) void'(exp_bus.pop_back());
    chk_eq({nm, "_nwords"}, words.size(), n_words);
    for (int k = 0; k < n_words && k < words.size(); k++) begin
      int i, s;
      i = k / N_SEL; s = k % N_SEL;
      chk_eq($sformatf("%s_w%0d_data", nm, k), words[k].data, cfg_salt + i * 16 + s);
      chk_eq($sformatf("%s_w%0d_idx", nm, k), words[k].idx, i % 32);
      chk_eq($sformatf("%s_w%0d_sel", nm, k), words[k].sel, s);
      chk_eq($sformatf("%s_w%0d_last", nm, k), words[k].last, !ab && (k == n_words - 1));
    end
    chk_eq({nm, "_nbus"}, bus_log.size(), exp_bus.size());
    for (int k = 0; k < exp_bus.size() && k < bus_log.size(); k++)
      chk_eq($sformatf("%s_bus%0d", nm, k), bus_log[k], exp_bus[k]);
    chk_eq({nm, "_done_cnt"}, done_cnt, 1);
    chk_eq({nm, "_aborted"}, aborted_o, ab);
    chk_eq({nm, "_busy_end"}, busy_o, 1'b0);
    chk_eq({nm, "_stable"}, stab_bad, 0);
    if (n_words > 0) chk_eq({nm, "_done_lat"}, done_cyc - last_hs_cyc, 1);
    else chk_eq({nm, "_ns0_lat"}, (done_cyc - rv_cyc >= 1) && (done_cyc - rv_cyc <= 3), 1'b1);
  endtask

  // Stimulus sequence
  initial begin
    logic [31:0] salt;
    logic [5:0]  raw;
    int          n_eff, t;
    cke_i = 1'b1; arst_i = 1'b1; start_i = 1'b0; abort_req = 0;
    cfg_ns = 0; cfg_salt = 0; cfg_rdy_hi = 0; cfg_rv_lo = 0; cfg_rv_hi = 0;
    cfg_bp = 0; cfg_hold = 0; cfg_ab = 0; clr_req = 1;
    for (int i = 0; i < 3; i++) step();
    clr_req = 0;
    chk_eq("rst_busy", busy_o, 1'b0);      chk_eq("rst_done", done_o, 1'b0);
    chk_eq("rst_aborted", aborted_o, 1'b0); chk_eq("rst_avalid", iob.avalid, 1'b0);
    chk_eq("rst_addr", iob.addr, 4'h0);     chk_eq("rst_wdata", iob.wdata, 32'h0);
    chk_eq("rst_wstrb", iob.wstrb, 4'h0);   chk_eq("rst_valid", valid_o, 1'b0);
    chk_eq("rst_data", data_o, 32'h0);      chk_eq("rst_idx", idx_o, 5'h0);
    chk_eq("rst_sel", sel_o, 8'h0);         chk_eq("rst_last", last_o, 1'b0);
    arst_i = 1'b0;
    step();

    do_run(32'd3, 32'h0, 0, 0, 0, 0, 0, 1, 0, "basic");
    check_run("basic", 3, 0);

    do_run(32'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0, "ns0");
    check_run("ns0", 0, 0);

    salt = $urandom & 32'hFFFF_0000;
    do_run(32'd32, salt, 3, 0, 3, 1, 0, 0, 0, "rand32");
    check_run("rand32", 32, 0);

    salt = $urandom & 32'hFFFF_0000;
    cfg_ns = 32'h0000_0127 | ($urandom & 32'hFFFF_F000);
    raw = cfg_ns[5:0];
    n_eff = (raw > 6'd32) ? 32 : int'(raw);
    do_run(cfg_ns, salt, 3, 0, 3, 1, 0, 0, 0, "sat");
    check_run("sat", n_eff, 0);

    do_run(32'd3, 32'h0, 0, 2, 2, 0, 1, 0, 0, "abort");
    check_run("abort", 3, 1);

    abort_req = 1; step(); abort_req = 0;
    for (int i = 0; i < 3; i++) step();
    chk_eq("idle_abort_busy", busy_o, 1'b0);
    chk_eq("idle_abort_avalid", iob.avalid, 1'b0);
    chk_eq("idle_abort_sticky", aborted_o, 1'b1);
    chk_eq("idle_abort_done", done_o, 1'b0);

    do_run(32'd3, 32'h0, 1, 0, 2, 1, 0, 0, 1, "startab");
    check_run("startab", 3, 0);

    cfg_ns = 32'd3; cfg_salt = 32'h0; cfg_rdy_hi = 0; cfg_rv_lo = 0; cfg_rv_hi = 0;
    cfg_bp = 0; cfg_ab = 0; cfg_hold = 1;
    clr_req = 1; step(); clr_req = 0;
    start_i = 1'b1; step(); start_i = 1'b0;
    t = 0;
    while (valid_o !== 1'b1 && t < 200) begin
      step(); t++;
    end
    chk_eq("rstmid_valid_seen", valid_o, 1'b1);
    arst_i = 1'b1; step();
    chk_eq("rstmid_valid", valid_o, 1'b0);
    chk_eq("rstmid_busy", busy_o, 1'b0);
    chk_eq("rstmid_avalid", iob.avalid, 1'b0);
    arst_i = 1'b0; cfg_hold = 0; step();

    do_run(32'd3, 32'h0000_0500, 2, 0, 3, 1, 0, 0, 0, "after_rst");
    check_run("after_rst", 3, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
